// File: rtl/fetch_seq_pkg.sv
// Shared encodings for the fetch sequencer: FSM states, opcodes, instruction fields
// and next-PC select.
package fetch_seq_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      FETCH      = 3'd1,
      FETCH_WAIT = 3'd2,
      DECODE     = 3'd3,
      EXECUTE    = 3'd4,
      MEM        = 3'd5,
      WRITEBACK  = 3'd6,
      HALT       = 3'd7
   } state_t;

   localparam logic [3:0] OP_ALU  = 4'h0;
   localparam logic [3:0] OP_ADDI = 4'h1;
   localparam logic [3:0] OP_LW   = 4'h2;
   localparam logic [3:0] OP_SW   = 4'h3;
   localparam logic [3:0] OP_BEQ  = 4'h4;
   localparam logic [3:0] OP_J    = 4'h5;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int RS_MSB  = 11;
   localparam int RS_LSB  = 9;
   localparam int RT_MSB  = 8;
   localparam int RT_LSB  = 6;
   localparam int IMM_MSB = 5;
   localparam int IMM_LSB = 0;

   typedef enum logic [1:0] {
      PC_INC    = 2'd0,
      PC_BRANCH = 2'd1,
      PC_JUMP   = 2'd2
   } pc_sel_t;

   typedef struct packed {
      logic [3:0] opcode;
      logic [2:0] rs;
      logic [2:0] rt;
      logic [5:0] imm;
   } inst_fields_t;

   function automatic inst_fields_t split_inst(input logic [15:0] inst);
      inst_fields_t f;
      f.opcode = inst[OPC_MSB:OPC_LSB];
      f.rs     = inst[RS_MSB:RS_LSB];
      f.rt     = inst[RT_MSB:RT_LSB];
      f.imm    = inst[IMM_MSB:IMM_LSB];
      return f;
   endfunction

endpackage

// File: rtl/fetch_seq_pc.sv
// Program counter: loads the increment / branch / jump target when advance is high,
// otherwise holds. All arithmetic wraps modulo 2^ADDR_W.
module fetch_seq_pc
   import fetch_seq_pkg::*;
#(
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              advance,
   input  pc_sel_t           sel,
   input  logic [ADDR_W-1:0] target,
   output logic [ADDR_W-1:0] pc
);

   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] pc_nxt;

   assign pc_inc = pc + ADDR_W'(1);

   always_comb begin
      pc_nxt = pc_inc;
      case (sel)
         PC_BRANCH: pc_nxt = pc_inc + target;
         PC_JUMP:   pc_nxt = target;
         default:   pc_nxt = pc_inc;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       pc <= '0;
      else if (advance) pc <= pc_nxt;
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit ISA.
// Define FETCH_SEQ_SINGLE_STEP_EN to return to IDLE after every completed instruction.
module fetch_sequencer
   import fetch_seq_pkg::*;
#(
   parameter int ADDR_W = 3,
   parameter int INST_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stall,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [INST_W-1:0] imem_inst,
   input  logic              alu_zero,
   output logic [ADDR_W-1:0] pc,
   output logic [INST_W-1:0] ir,
   output logic [3:0]        opcode,
   output logic [2:0]        rs,
   output logic [2:0]        rt,
   output logic [5:0]        imm,
   output logic              alu_en,
   output logic              mem_read,
   output logic              mem_write,
   output logic              reg_write,
   output logic              busy,
   output logic              halted
);

   // Where the FSM goes once an instruction has fully retired.
`ifdef FETCH_SEQ_SINGLE_STEP_EN
   localparam state_t DONE_STATE = IDLE;
`else
   localparam state_t DONE_STATE = FETCH;
`endif

   state_t       state, state_nxt;
   pc_sel_t      pc_sel;
   logic         pc_adv;
   inst_fields_t fields;

   assign fields = split_inst(ir);
   assign opcode = fields.opcode;
   assign rs     = fields.rs;
   assign rt     = fields.rt;
   assign imm    = fields.imm;

   assign imem_addr = pc;
   assign busy      = (state != IDLE) && (state != HALT);
   assign halted    = (state == HALT);

   fetch_seq_pc #(.ADDR_W(ADDR_W)) u_pc (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (pc_adv),
      .sel     (pc_sel),
      .target  (ADDR_W'(fields.imm)),
      .pc      (pc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ir    <= '0;
      end else begin
         state <= state_nxt;
         if (state == FETCH_WAIT && !stall) ir <= imem_inst;
      end
   end

   always_comb begin
      state_nxt = state;
      alu_en    = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      pc_adv    = 1'b0;
      pc_sel    = PC_INC;
      case (state)
         IDLE:       if (start) state_nxt = FETCH;
         FETCH:      if (!stall) state_nxt = FETCH_WAIT;
         FETCH_WAIT: if (!stall) state_nxt = DECODE;
         DECODE:     if (!stall) state_nxt = (opcode == OP_HALT) ? HALT : EXECUTE;
         EXECUTE: begin
            alu_en = 1'b1;
            if (opcode == OP_J)                    pc_sel = PC_JUMP;
            else if (opcode == OP_BEQ && alu_zero) pc_sel = PC_BRANCH;
            // PC moves exactly once per instruction, on the edge leaving EXECUTE.
            if (!stall) begin
               pc_adv = 1'b1;
               case (opcode)
                  OP_LW, OP_SW: state_nxt = MEM;
                  OP_BEQ, OP_J: state_nxt = DONE_STATE;
                  default:      state_nxt = WRITEBACK;
               endcase
            end
         end
         MEM: begin
            mem_read  = (opcode == OP_LW);
            mem_write = (opcode == OP_SW);
            if (!stall) state_nxt = (opcode == OP_LW) ? WRITEBACK : DONE_STATE;
         end
         WRITEBACK: begin
            reg_write = 1'b1;
            if (!stall) state_nxt = DONE_STATE;
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
   end

endmodule
